alu_seq_exec: RTL

Parametrised ALU execution unit combining the op/funct7/funct3 decode with a sequential datapath. Single-cycle operations (add, sub, logic, shifts, set-less-than) complete with one-cycle latency. Multiply and divide/remainder run as WIDTH-cycle iterative operations. The block sits between the register-read stage and writeback, with valid/ready handshakes on both sides.

---
 rtl/alu_seq_exec.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/alu_seq_exec.sv
// alu_seq_exec: decoded ALU with one-cycle logic/arith ops and WIDTH-cycle iterative multiply/divide.
// Holds one result at a time behind valid/ready handshakes on both sides.
module alu_seq_exec #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    localparam logic [3:0] C_ADD = 4'd0, C_SUB = 4'd1, C_AND = 4'd2, C_OR = 4'd3,
                           C_XOR = 4'd4, C_SLL = 4'd5, C_SRL = 4'd6, C_SLT = 4'd7,
                           C_MUL = 4'd8, C_MULHU = 4'd9, C_DIVU = 4'd10, C_REMU = 4'd11,
                           C_ILL = 4'd15;

    state_t                 state_q, state_d;
    logic [SHAMT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]       opnd_q, opnd_d;
    logic                   hi_q, hi_d;
    logic [WIDTH-1:0]       result_q, result_d;
    logic                   zero_q, zero_d;
    logic                   illegal_q, illegal_d;

    logic [3:0]             code;
    logic [WIDTH-1:0]       alu_res;
    logic                   accept;
    logic [WIDTH:0]         msum, rsh, rdiff;
    logic [2*WIDTH-1:0]     mul_step, div_step, step;
    logic [WIDTH-1:0]       fin;

    always_comb begin
        code = C_ILL;
        case (op)
            2'b00: code = C_ADD;
            2'b01: code = C_SUB;
            2'b10: case ({funct7, funct3})
                10'b0000000_000: code = C_ADD;
                10'b0100000_000: code = C_SUB;
                10'b0000000_111: code = C_AND;
                10'b0000000_110: code = C_OR;
                10'b0000000_100: code = C_XOR;
                10'b0000000_001: code = C_SLL;
                10'b0000000_101: code = C_SRL;
                10'b0000000_011: code = C_SLT;
                10'b0000001_000: code = C_MUL;
                10'b0000001_011: code = C_MULHU;
                10'b0000001_101: code = C_DIVU;
                10'b0000001_111: code = C_REMU;
                default:         code = C_ILL;
            endcase
            default: case (funct3)
                3'b000:  code = C_ADD;
                3'b111:  code = C_AND;
                3'b110:  code = C_OR;
                3'b100:  code = C_XOR;
                3'b001:  code = C_SLL;
                3'b101:  code = C_SRL;
                3'b011:  code = C_SLT;
                default: code = C_ILL;
            endcase
        endcase
    end

    always_comb begin
        alu_res = '0;
        case (code)
            C_ADD:   alu_res = a + b;
            C_SUB:   alu_res = a - b;
            C_AND:   alu_res = a & b;
            C_OR:    alu_res = a | b;
            C_XOR:   alu_res = a ^ b;
            C_SLL:   alu_res = a << b[SHAMT_W-1:0];
            C_SRL:   alu_res = a >> b[SHAMT_W-1:0];
            C_SLT:   alu_res = WIDTH'($signed(a) < $signed(b));
            default: alu_res = '0;
        endcase
    end

    // Multiply: acc = {partial sum, remaining multiplier bits}; divide: acc = {remainder, dividend/quotient}.
    assign msum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, acc_q[0] ? opnd_q : '0};
    assign mul_step = {msum, acc_q[WIDTH-1:1]};
    assign rsh      = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign rdiff    = rsh - {1'b0, opnd_q};
    assign div_step = rdiff[WIDTH] ? {rsh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                   : {rdiff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    assign step     = (state_q == MUL) ? mul_step : div_step;
    assign fin      = hi_q ? step[2*WIDTH-1:WIDTH] : step[WIDTH-1:0];

    assign in_ready  = (state_q == IDLE) || (state_q == DONE && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == MUL) || (state_q == DIV);
    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        hi_d      = hi_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        if (busy) begin
            acc_d = step;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == SHAMT_W'(WIDTH-1)) begin
                state_d   = DONE;
                result_d  = fin;
                zero_d    = (fin == '0);
                illegal_d = 1'b0;
            end
        end else if (accept) begin
            cnt_d = '0;
            hi_d  = (code == C_MULHU) || (code == C_REMU);
            if (code == C_MUL || code == C_MULHU) begin
                state_d = MUL;
                opnd_d  = a;
                acc_d   = {{WIDTH{1'b0}}, b};
            end else if (code == C_DIVU || code == C_REMU) begin
                state_d = DIV;
                opnd_d  = b;
                acc_d   = {{WIDTH{1'b0}}, a};
            end else begin
                state_d   = DONE;
                result_d  = alu_res;
                zero_d    = (alu_res == '0);
                illegal_d = (code == C_ILL);
            end
        end else if (state_q == DONE && out_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            hi_q      <= 1'b0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            hi_q      <= hi_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end
endmodule
